// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one single-ported RAM
// with a variable-latency ready handshake, data priority and fetch fairness.
module mem_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] iaddr,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_load,
    input  logic        ram_rdy,
    output logic        err,
    output logic [1:0]  dbg_state_o
);

    // Handshake: a strobe (ram_ren/ram_wen) is held with stable address/data
    // until the cycle ram_rdy=1 is seen; that cycle completes the access.
    // Requests are levels held by the requester until its one-cycle hit.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2,
        HIT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ifair_q, ifair_d;
    logic               err_q, err_d;
    logic               sel_data_q, sel_data_d;
    logic               op_write_q, op_write_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        store_q, store_d;
    logic [31:0]        iload_q, iload_d;
    logic [31:0]        dload_q, dload_d;

    logic d_req;
    assign d_req = dREN | dWEN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ifair_q    <= 1'b0;
            err_q      <= 1'b0;
            sel_data_q <= 1'b0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            store_q    <= '0;
            iload_q    <= '0;
            dload_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ifair_q    <= ifair_d;
            err_q      <= err_d;
            sel_data_q <= sel_data_d;
            op_write_q <= op_write_d;
            addr_q     <= addr_d;
            store_q    <= store_d;
            iload_q    <= iload_d;
            dload_q    <= dload_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ifair_d    = ifair_q;
        err_d      = err_q;
        sel_data_d = sel_data_q;
        op_write_d = op_write_q;
        addr_d     = addr_q;
        store_d    = store_q;
        iload_d    = iload_q;
        dload_d    = dload_q;

        case (state_q)
            IDLE: begin
                // A pending fetch wins once after a data access it waited on.
                if (d_req && !(ifair_q && iREN)) begin
                    state_d    = DACC;
                    sel_data_d = 1'b1;
                    op_write_d = dWEN;
                    addr_d     = daddr;
                    store_d    = dstore;
                    cnt_d      = '0;
                end else if (iREN) begin
                    state_d    = IACC;
                    sel_data_d = 1'b0;
                    op_write_d = 1'b0;
                    addr_d     = iaddr;
                    cnt_d      = '0;
                end
            end
            DACC, IACC: begin
                if (ram_rdy) begin
                    state_d = HIT;
                    if (state_q == IACC) begin
                        iload_d = ram_load;
                        ifair_d = 1'b0;
                    end else begin
                        if (!op_write_q) dload_d = ram_load;
                        if (iREN)        ifair_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A withdrawn request suppresses its hit; the loaded data is kept anyway.
    assign ihit        = (state_q == HIT) && !sel_data_q && iREN;
    assign dhit        = (state_q == HIT) &&  sel_data_q && d_req;
    assign ram_ren     = (state_q == IACC) || ((state_q == DACC) && !op_write_q);
    assign ram_wen     = (state_q == DACC) && op_write_q;
    assign ram_addr    = addr_q;
    assign ram_store   = store_q;
    assign iload       = iload_q;
    assign dload       = dload_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority/fairness, write latency,
// timeout, mid-access reset and withdrawn request.
module tb_mem_arbiter;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DACC = 2'd1;
  localparam logic [1:0] S_IACC = 2'd2;
  localparam logic [1:0] S_HIT  = 2'd3;

  logic        clk;
  logic        rst;
  logic        iren, dren, dwen;
  logic [31:0] iaddr, daddr, dstore;
  logic        ihit, dhit;
  logic [31:0] iload, dload;
  logic        ram_ren, ram_wen;
  logic [31:0] ram_addr, ram_store, ram_load;
  logic        ram_rdy;
  logic        err;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
    .CLK(clk), .RST(rst),
    .iREN(iren), .dREN(dren), .dWEN(dwen),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ram_ren(ram_ren), .ram_wen(ram_wen),
    .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_rdy(ram_rdy),
    .err(err), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; iren = 0; dren = 0; dwen = 0;
    iaddr = 0; daddr = 0; dstore = 0; ram_load = 0; ram_rdy = 0;
    @(negedge clk);
    tick();
    tick();
    check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("rst_strobes", {30'd0, ram_ren, ram_wen}, 32'd0);
    check("rst_hits", {29'd0, ihit, dhit, err}, 32'd0);
    check("rst_iload", iload, 32'd0);
    check("rst_dload", dload, 32'd0);
    rst = 1'b0;

    // instruction fetch, 1-cycle RAM
    iren = 1; iaddr = 32'h40;
    check("t1_idle_noren", {31'd0, ram_ren}, 32'd0);
    tick();
    check("t1_ren", {31'd0, ram_ren}, 32'd1);
    check("t1_addr", ram_addr, 32'h40);
    check("t1_no_ihit_yet", {31'd0, ihit}, 32'd0);
    ram_rdy = 1; ram_load = 32'h8C010004;
    tick();
    check("t1_ihit", {31'd0, ihit}, 32'd1);
    check("t1_dhit", {31'd0, dhit}, 32'd0);
    check("t1_iload", iload, 32'h8C010004);
    check("t1_ren_drop", {31'd0, ram_ren}, 32'd0);
    iren = 0; ram_rdy = 0;
    tick();
    check("t1_ihit_once", {31'd0, ihit}, 32'd0);

    // simultaneous iREN and dREN: data first, then fetch despite dREN
    iren = 1; iaddr = 32'h0; dren = 1; daddr = 32'h100;
    tick();
    check("t2_dacc_state", {30'd0, dbg_state}, {30'd0, S_DACC});
    check("t2_daddr", ram_addr, 32'h100);
    check("t2_ren", {30'd0, ram_ren, ram_wen}, 32'd2);
    ram_rdy = 1; ram_load = 32'hDEADBEEF;
    tick();
    check("t2_dhit", {30'd0, dhit, ihit}, 32'd2);
    check("t2_dload", dload, 32'hDEADBEEF);
    ram_rdy = 0; ram_load = 32'h0;
    tick();
    check("t2_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
    tick();
    check("t2_fair_iacc", {30'd0, dbg_state}, {30'd0, S_IACC});
    check("t2_iaddr", ram_addr, 32'h0);
    ram_rdy = 1; ram_load = 32'h11112222;
    tick();
    check("t2_ihit", {30'd0, dhit, ihit}, 32'd1);
    check("t2_iload", iload, 32'h11112222);
    iren = 0; dren = 0; ram_rdy = 0;
    tick();

    // data write, 3-cycle latency, inputs change mid-access
    dwen = 1; daddr = 32'h200; dstore = 32'h12345678;
    tick();
    check("t3_wen_c1", {30'd0, ram_ren, ram_wen}, 32'd1);
    check("t3_addr_c1", ram_addr, 32'h200);
    check("t3_store_c1", ram_store, 32'h12345678);
    daddr = 32'hFFF; dstore = 32'h0;
    tick();
    check("t3_wen_c2", {31'd0, ram_wen}, 32'd1);
    check("t3_addr_c2", ram_addr, 32'h200);
    check("t3_store_c2", ram_store, 32'h12345678);
    tick();
    check("t3_wen_c3", {31'd0, ram_wen}, 32'd1);
    check("t3_no_dhit_c3", {31'd0, dhit}, 32'd0);
    ram_rdy = 1; ram_load = 32'hBAD0BAD0;
    tick();
    check("t3_dhit", {31'd0, dhit}, 32'd1);
    check("t3_wen_drop", {31'd0, ram_wen}, 32'd0);
    check("t3_dload_kept", dload, 32'hDEADBEEF);
    dwen = 0; ram_rdy = 0;
    tick();
    check("t3_dhit_once", {31'd0, dhit}, 32'd0);

    // timeout: 8 strobe cycles, then abort with sticky err
    iren = 1; iaddr = 32'h80;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("t4_ren_c%0d", i), {31'd0, ram_ren}, 32'd1);
    end
    check("t4_err_early", {31'd0, err}, 32'd0);
    tick();
    check("t4_ren_drop", {31'd0, ram_ren}, 32'd0);
    check("t4_err", {31'd0, err}, 32'd1);
    check("t4_no_ihit", {31'd0, ihit}, 32'd0);
    check("t4_iload_kept", iload, 32'h11112222);
    tick();
    check("t4_retry_iacc", {30'd0, dbg_state}, {30'd0, S_IACC});
    ram_rdy = 1; ram_load = 32'hCAFE0001;
    tick();
    check("t4_retry_ihit", {31'd0, ihit}, 32'd1);
    check("t4_retry_iload", iload, 32'hCAFE0001);
    check("t4_err_sticky", {31'd0, err}, 32'd1);
    ram_rdy = 0;
    tick();

    // set ifair, then reset during a data write
    dren = 1; daddr = 32'h100;
    tick();
    check("t5_dacc", {30'd0, dbg_state}, {30'd0, S_DACC});
    ram_rdy = 1; ram_load = 32'h00000055;
    tick();
    check("t5_dhit", {31'd0, dhit}, 32'd1);
    iren = 0; dren = 0; ram_rdy = 0; dwen = 1; daddr = 32'h300; dstore = 32'h5;
    tick();
    tick();
    check("t5_wen", {31'd0, ram_wen}, 32'd1);
    rst = 1;
    tick();
    check("t5_rst_wen", {30'd0, ram_wen, ram_ren}, 32'd0);
    check("t5_rst_hits", {29'd0, dhit, ihit, err}, 32'd0);
    check("t5_rst_loads", iload | dload, 32'd0);
    rst = 0; dwen = 0; iren = 1; dren = 1; iaddr = 32'h44; daddr = 32'h104;
    tick();
    check("t5_ifair_clr", ram_addr, 32'h104);
    check("t5_ren", {31'd0, ram_ren}, 32'd1);
    ram_rdy = 1; ram_load = 32'h77;
    tick();
    check("t5_dhit2", {31'd0, dhit}, 32'd1);
    dren = 0; ram_rdy = 0;
    tick();
    tick();
    check("t5_iaddr", ram_addr, 32'h44);
    ram_rdy = 1; ram_load = 32'h99;
    tick();
    check("t5_ihit", {31'd0, ihit}, 32'd1);
    check("t5_iload", iload, 32'h99);
    iren = 0; ram_rdy = 0;
    tick();

    // request withdrawn mid-access
    dren = 1; daddr = 32'h10;
    tick();
    dren = 0;
    tick();
    check("t6_still_dacc", {31'd0, ram_ren}, 32'd1);
    ram_rdy = 1; ram_load = 32'h0000ABCD;
    tick();
    check("t6_no_dhit", {31'd0, dhit}, 32'd0);
    check("t6_hit_state", {30'd0, dbg_state}, {30'd0, S_HIT});
    check("t6_dload", dload, 32'h0000ABCD);
    ram_rdy = 0;
    tick();
    check("t6_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("t6_ren_off", {31'd0, ram_ren}, 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the request unit. It consumes iREN/dREN/dWEN plus addresses and store data, and produces the ihit/dhit/iload/dload that the request unit and pipeline consume.
- Arbitrates the instruction and data ports onto one single-ported RAM interface with a variable-latency ready handshake.
- Data port has priority, with one-slot anti-starvation for fetch. Hung accesses are aborted by a timeout.

Parameters:
- TIMEOUT, 64: max cycles in an access state without ram_rdy before abort; must be >= 2.
- CNT_W, 7: width of the access cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- iREN  in  1  instruction read request (level, held until ihit)
- dREN  in  1  data read request (level, held until dhit)
- dWEN  in  1  data write request (level, held until dhit)
- iaddr  in  32  instruction word address
- daddr  in  32  data word address
- dstore  in  32  data write value
- ihit  out  1  one-cycle pulse: instruction read complete
- dhit  out  1  one-cycle pulse: data read or write complete
- iload  out  32  registered instruction read data
- dload  out  32  registered data read data
- ram_ren  out  1  RAM read strobe
- ram_wen  out  1  RAM write strobe
- ram_addr  out  32  RAM address
- ram_store  out  32  RAM write data
- ram_load  in  32  RAM read data, valid when ram_rdy=1
- ram_rdy  in  1  RAM completion for the current strobe
- err  out  1  sticky timeout flag

Behaviour:
- Reset (RST=1 at a clock edge, also mid-access):
  - state=IDLE, all outputs 0, counter=0, ifair=0, latched request registers cleared.
  - Any in-flight RAM access is abandoned; ram_ren/ram_wen drop the following cycle.
- States: IDLE, DACC, IACC, HIT.
- IDLE arbitration:
  - Choose data if (dREN|dWEN) and !(ifair & iREN); otherwise choose instruction if iREN; otherwise stay in IDLE.
  - Latch the chosen op, address and dstore into internal registers; go to DACC or IACC; counter=0.
- dREN and dWEN both high: treated as a write. A read is never issued.
- ifair:
  - Set when a DACC completes while iREN is high.
  - Cleared when an IACC completes.
  - Guarantees instruction service at least every second access.
- DACC/IACC:
  - ram_ren or ram_wen=1, with ram_addr/ram_store from the latched registers. Both are stable for the whole state, independent of input changes.
  - Counter increments each cycle.
- On ram_rdy=1 in DACC/IACC:
  - Capture ram_load into dload (data read) or iload (instruction read). Writes leave dload unchanged.
  - Go to HIT; strobes drop.
- HIT:
  - Assert dhit or ihit for exactly this one cycle, matching the completed port.
  - The hit is suppressed if that port's request input is low in HIT (request withdrawn mid-access). The RAM access still completed; loads are still updated.
  - Next state is IDLE. No back-to-back hits; minimum request-to-hit latency is 2 cycles (request seen in IDLE at cycle 0, ram_rdy in cycle 1, hit in cycle 2).
- Timeout:
  - If the counter reaches TIMEOUT-1 in DACC/IACC with ram_rdy=0, set err=1 (sticky until RST) and go to IDLE.
  - No hit, no load update, ifair unchanged.
- ram_rdy while in IDLE or HIT is ignored.
- iload/dload hold their last value until overwritten.
- Counter never wraps, because TIMEOUT < 2^CNT_W.

Test Plan:
- Instruction read, RAM responds 1 cycle after the strobe: iREN=1, iaddr=0x40, ram_load=0x8C010004 → ram_ren=1 with ram_addr=0x40; ihit pulses at cycle 2; iload=0x8C010004; dhit stays 0.
- Simultaneous iREN and dREN: daddr=0x100 served first (dhit, dload=0xDEADBEEF); next access is iaddr=0x0 despite dREN remaining high; ihit follows.
- Data write with 3-cycle RAM latency: dWEN=1, daddr=0x200, dstore=0x12345678 → ram_wen=1 held 3 cycles with constant address/data; dhit pulses once; dload unchanged.
- Timeout with TIMEOUT=8: iREN=1 and ram_rdy held 0 → strobe drops after 8 cycles; err=1 persists; no ihit; a later request completes normally with err still 1.
- Reset mid-access during DACC (RST=1 one cycle) → next cycle ram_wen=0 and dhit=0; err, ifair and loads all 0; fresh iREN is then served normally.
- Request withdrawn: dREN drops while in DACC; ram_rdy arrives → no dhit; dload is updated; arbiter returns to IDLE.
